// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box tables, lookup helpers and the sub_word_engine state encoding.
package aes_sbox_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Forward S-box: row = high nibble, column = low nibble
   localparam logic [BYTE_W-1:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [BYTE_W-1:0] SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] b);
      return SBOX_FWD[b];
   endfunction

   function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] b);
      return SBOX_INV[b];
   endfunction

endpackage

// File: rtl/sbox_lane.sv
// One physical S-box lookup: a single byte through the forward or inverse table.
module sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic [BYTE_W-1:0] din_i,
   input  logic              inv_i,
   output logic [BYTE_W-1:0] sub_c_o
);

   always_comb begin
      sub_c_o = inv_i ? sbox_inv(din_i) : sbox_fwd(din_i);
   end

endmodule

// File: rtl/sub_word_engine.sv
// Handshaked AES SubWord/InvSubWord engine with optional RotWord; LANES S-boxes
// are time-multiplexed over the NBYTES word, one lane-group per BUSY cycle.
module sub_word_engine
   import aes_sbox_pkg::*;
#(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned LANES  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*NBYTES-1:0]    in_data,
   input  logic                   in_inv,
   input  logic                   in_rot,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NBYTES-1:0]    out_data
);

   localparam int unsigned DW = BYTE_W * NBYTES;
   localparam int unsigned C  = NBYTES / LANES;
   localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

   // Word viewed as C groups of LANES bytes; group g holds bytes g*LANES .. g*LANES+LANES-1
   typedef logic [C-1:0][LANES-1:0][BYTE_W-1:0] word_t;

   if ((NBYTES % LANES) != 0) begin : g_cfg_check
      $error("sub_word_engine: NBYTES must be a multiple of LANES");
   end

   state_e                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   word_t                         word_q, word_d;
   word_t                         result_q, result_d;
   logic                          inv_q, inv_d;
   logic [DW-1:0]                 rot_word;
   logic                          accept;
   logic [LANES-1:0][BYTE_W-1:0]  lane_in;
   logic [LANES-1:0][BYTE_W-1:0]  lane_out;

   // Left rotate by one byte; degenerates to identity when NBYTES == 1
   assign rot_word = in_rot ? ((in_data << BYTE_W) | (in_data >> (DW - BYTE_W))) : in_data;
   assign accept   = in_valid && in_ready;
   assign lane_in  = word_q[cnt_q];

   for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
      sbox_lane u_lane (
         .din_i   (lane_in[g]),
         .inv_i   (inv_q),
         .sub_c_o (lane_out[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         word_q   <= '0;
         result_q <= '0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         result_q <= result_d;
         inv_q    <= inv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      inv_d    = inv_q;
      result_d = result_q;

      // Capture is identical from IDLE and from a draining DONE
      if (accept) begin
         word_d = word_t'(rot_word);
         inv_d  = in_inv;
         cnt_d  = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) state_d = BUSY;
         end
         BUSY: begin
            result_d[cnt_q] = lane_out;
            if (cnt_q == CW'(C - 1)) state_d = DONE;
            else                     cnt_d   = cnt_q + CW'(1);
         end
         DONE: begin
            if (out_ready) state_d = accept ? BUSY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = result_q;
      unique case (state_q)
         IDLE: in_ready = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sub_word_engine.sv
// Self-checking bench: three engine configurations against a GF(2^8)-derived S-box model.
module tb_sub_word_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  in_valid, in_inv, in_rot, out_ready;
   wire  [2:0]  in_ready, out_valid;
   logic [31:0] in_data_a, in_data_b;
   wire  [31:0] out_data_a, out_data_b;
   logic [63:0] in_data_c;
   wire  [63:0] out_data_c;

   int total = 0;
   int bad   = 0;
   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];

   typedef struct {
      int          k;
      logic [63:0] d;
      logic        inv;
      logic        rot;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs [9];

   always #5 clk = ~clk;

   sub_word_engine #(.NBYTES(4), .LANES(4)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data_a),
      .in_inv(in_inv[0]), .in_rot(in_rot[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data_a));
   sub_word_engine #(.NBYTES(4), .LANES(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data_b),
      .in_inv(in_inv[1]), .in_rot(in_rot[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data_b));
   sub_word_engine #(.NBYTES(8), .LANES(2)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data_c),
      .in_inv(in_inv[2]), .in_rot(in_rot[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data_c));

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse then affine map
   function automatic logic [7:0] model_fwd(input logic [7:0] x);
      logic [7:0] r = x;
      logic [7:0] s;
      for (int i = 0; i < 253; i++) r = gf_mul(r, x);
      s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic int nbytes(input int k);
      return (k == 2) ? 8 : 4;
   endfunction

   function automatic int cycles(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic logic [63:0] rd(input int k);
      case (k)
         0:       return {32'h0, out_data_a};
         1:       return {32'h0, out_data_b};
         default: return out_data_c;
      endcase
   endfunction

   task automatic drive_data(input int k, input logic [63:0] d);
      case (k)
         0:       in_data_a = d[31:0];
         1:       in_data_b = d[31:0];
         default: in_data_c = d;
      endcase
   endtask

   function automatic logic [63:0] ref_word(input int k, input logic [63:0] d, input logic inv, input logic rot);
      int nb = nbytes(k);
      logic [7:0] b [8];
      logic [7:0] r;
      logic [63:0] res = '0;
      for (int i = 0; i < nb; i++) b[i] = d[8*i +: 8];
      for (int i = 0; i < nb; i++) begin
         r = rot ? b[(i + nb - 1) % nb] : b[i];
         res[8*i +: 8] = inv ? inv_t[r] : fwd_t[r];
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction from IDLE: accept, wait (bounded) for result, check, drain
   task automatic do_word(input int k, input logic [63:0] d, input logic inv, input logic rot,
                          input logic [63:0] exp, input string tag);
      int lat = 1;
      int busy_rdy = 0;
      check({tag, " idle_ready"}, 64'(in_ready[k]), 64'd1);
      in_valid[k] = 1'b1; in_inv[k] = inv; in_rot[k] = rot; drive_data(k, d);
      tick();
      in_valid[k] = 1'b0;
      drive_data(k, {$urandom, $urandom});
      in_inv[k] = 1'($urandom); in_rot[k] = 1'($urandom);
      while (!out_valid[k] && lat < 50) begin
         if (in_ready[k]) busy_rdy++;
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(cycles(k) + 1));
      check({tag, " busy_ready"}, 64'(busy_rdy), 64'd0);
      check({tag, " data"}, rd(k), exp);
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      check({tag, " drained"}, 64'(out_valid[k]), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d, e;
      logic inv, rot;
      rst = 1'b1;
      in_valid = '0; in_inv = '0; in_rot = '0; out_ready = '0;
      in_data_a = '0; in_data_b = '0; in_data_c = '0;

      for (int x = 0; x < 256; x++) fwd_t[x] = model_fwd(8'(x));
      for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

      vecs[0] = '{0, 64'h00FF5310, 1'b0, 1'b0, 64'h6316EDCA};
      vecs[1] = '{0, 64'h6316EDCA, 1'b1, 1'b0, 64'h00FF5310};
      vecs[2] = '{0, 64'h00000000, 1'b0, 1'b0, 64'h63636363};
      vecs[3] = '{0, 64'h01020304, 1'b0, 1'b1, 64'h777BF27C};
      vecs[4] = '{1, 64'h00FF5310, 1'b0, 1'b0, 64'h6316EDCA};
      vecs[5] = '{1, 64'h01020304, 1'b0, 1'b1, 64'h777BF27C};
      vecs[6] = '{1, 64'h6316EDCA, 1'b1, 1'b0, 64'h00FF5310};
      vecs[7] = '{2, 64'h0001020304050607, 1'b0, 1'b0, 64'h637C777BF26B6FC5};
      vecs[8] = '{2, 64'h0001020304050607, 1'b0, 1'b1, 64'h7C777BF26B6FC563};

      repeat (3) tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset%0d out_valid", k), 64'(out_valid[k]), 64'd0);
         check($sformatf("reset%0d in_ready", k), 64'(in_ready[k]), 64'd1);
         check($sformatf("reset%0d out_data", k), rd(k), 64'd0);
      end

      for (int i = 0; i < 9; i++)
         do_word(vecs[i].k, vecs[i].d, vecs[i].inv, vecs[i].rot, vecs[i].exp, $sformatf("vec%0d", i));

      // Backpressure in DONE, then back-to-back accept on release
      in_valid[0] = 1'b1; in_inv[0] = 1'b0; in_rot[0] = 1'b0; in_data_a = 32'h00FF5310;
      tick();
      in_data_a = 32'h00000000;
      tick();
      for (int c = 0; c < 3; c++) begin
         check($sformatf("bp%0d out_valid", c), 64'(out_valid[0]), 64'd1);
         check($sformatf("bp%0d out_data", c), rd(0), 64'h6316EDCA);
         check($sformatf("bp%0d in_ready", c), 64'(in_ready[0]), 64'd0);
         tick();
      end
      out_ready[0] = 1'b1;
      #1;
      check("bp release in_ready", 64'(in_ready[0]), 64'd1);
      tick();
      out_ready[0] = 1'b0; in_valid[0] = 1'b0;
      check("b2b busy out_valid", 64'(out_valid[0]), 64'd0);
      tick();
      check("b2b second out_valid", 64'(out_valid[0]), 64'd1);
      check("b2b second out_data", rd(0), 64'h63636363);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;

      // Reset during the second BUSY cycle discards the word
      in_valid[1] = 1'b1; in_inv[1] = 1'b0; in_rot[1] = 1'b0; in_data_b = 32'h00FF5310;
      tick();
      in_valid[1] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midreset out_valid", 64'(out_valid[1]), 64'd0);
      check("midreset out_data", rd(1), 64'd0);
      check("midreset in_ready", 64'(in_ready[1]), 64'd1);
      do_word(1, 64'h00FF5310, 1'b0, 1'b0, 64'h6316EDCA, "after_reset");

      // Randomised words on every configuration
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 20; n++) begin
            d = {$urandom, $urandom};
            if (nbytes(k) == 4) d[63:32] = '0;
            inv = 1'($urandom);
            rot = 1'($urandom);
            e = ref_word(k, d, inv, rot);
            do_word(k, d, inv, rot, e, $sformatf("rnd%0d_%0d", k, n));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sub_word_engine.md
Name: sub_word_engine

Overview:
- Parametrised, handshaked AES byte-substitution engine; successor to the combinational 32-bit key SubWord lookup.
- Substitutes an NBYTES-wide word through the forward or inverse AES S-box, with optional RotWord applied first.
- Has a configurable number of physical S-box lanes, time-multiplexed over the word, so area can be traded against latency.
- Sits between the key-expansion controller, or the round datapath, and its consumer, using valid/ready on both sides.

Parameters:
- NBYTES, 4: bytes per word; data width is 8*NBYTES.
- LANES, 4: physical S-box lookups per cycle. NBYTES % LANES must be 0, otherwise elaboration fails.
- C (derived), NBYTES/LANES: number of processing cycles per word.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  engine can accept a word this cycle
- in_data  in  8*NBYTES  word to substitute
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled at accept
- in_rot  in  1  1 = apply RotWord before substitution; sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  8*NBYTES  substituted word

Behaviour:
- Byte i = bits [8i+7:8i]. S-box row = high nibble, column = low nibble. Standard FIPS-197 forward and inverse tables.
- RotWord is a left rotate by 8 bits: {in_data[8N-9:0], in_data[8N-1:8N-8]}. It is applied before lookup in both modes.
- Accept occurs when in_valid && in_ready on a rising edge. At accept, the engine captures the (rotated) word, the mode bit, and cnt = 0.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0. On accept, go to BUSY.
  - BUSY: in_ready = 0. Each cycle, lanes substitute bytes cnt*LANES .. cnt*LANES+LANES-1 into the result register, then cnt++. When cnt == C-1, go to DONE.
  - DONE: out_valid = 1, out_data = full result. in_ready = out_ready.
    - out_ready = 1 and in_valid = 1: accept the new word, go to BUSY (back-to-back).
    - out_ready = 1 and in_valid = 0: go to IDLE.
    - out_ready = 0: hold.
- Latency: accept in cycle 0 gives out_valid = 1 first in cycle C+1. Throughput is one word per C+1 cycles.
- Backpressure: while out_valid && !out_ready, out_data and out_valid stay stable and no input is accepted.
- Inputs are ignored outside the accept cycle; changing in_data while BUSY has no effect.
- Bytes not yet processed in the result register are don't-care internally. out_data is defined only when out_valid = 1.
- Reset (any state, including mid-BUSY or DONE) takes effect on the next edge:
  - state = IDLE, cnt = 0, out_valid = 0, out_data = 0, in_ready = 1 in the cycle after reset deasserts.
  - An in-flight word is discarded.
- Boundary case LANES == NBYTES: C = 1, exactly one BUSY cycle.
- Boundary case LANES == 1: C = NBYTES, and cnt wraps only by returning to IDLE/BUSY at accept.
- cnt width = max(1, clog2(C)).

Decomposition:
- Package aes_sbox_pkg holds:
  - the 256-entry forward and inverse S-box constant tables
  - functions sbox_fwd(byte) and sbox_inv(byte)
  - the state enum {IDLE, BUSY, DONE}
- Sub-module sbox_lane: one byte in, mode bit in, one byte out, combinational. Instantiated LANES times, with byte selection by cnt via a mux.

Test Plan:
- NBYTES=4, LANES=4, in_data = 0x00FF5310, inv = 0, rot = 0 -> out_data = 0x6316EDCA; out_valid is first high in cycle 2 after accept.
- Same config, in_data = 0x6316EDCA, inv = 1 -> 0x00FF5310; in_data = 0x00000000, inv = 0 -> 0x63636363.
- in_data = 0x01020304, rot = 1, inv = 0 -> rotated 0x02030401 -> out_data = 0x777BF27C.
- NBYTES=4, LANES=1, in_data = 0x00FF5310 -> out_valid first high 5 cycles after accept, value 0x6316EDCA; in_ready = 0 for cycles 1..4.
- out_ready held 0 for 3 cycles in DONE with in_valid = 1 -> out_data stable, in_ready = 0. Then out_ready = 1 with a new word -> back-to-back accept, and the second result is correct.
- Reset asserted in the second BUSY cycle (LANES=1) -> next cycle out_valid = 0, out_data = 0, in_ready = 1. A fresh word then completes correctly.
